// File: rtl/debug_pkg.sv
// Shared constants, FSM encoding and request-select codes for the MIPS debug read-back path.
package debug_pkg;

    localparam logic [5:0]  IDLE_SELECT = 6'b11_1111;
    localparam logic [31:0] EOD_MARKER  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_PRESENT,
        ST_EOD
    } seq_state_e;

    // Pipeline sources live in the 1_xxxxx half; registers 0..31 occupy 0_xxxxx.
    typedef enum logic [5:0] {
        SEL_MEM_DATA     = 6'b100000,
        SEL_MEM_INSTR    = 6'b100001,
        SEL_PC           = 6'b100010,
        SEL_FETCH_DATA   = 6'b100100,
        SEL_FETCH_CTRL   = 6'b100101,
        SEL_DECODE_DATA  = 6'b100110,
        SEL_DECODE_CTRL  = 6'b100111,
        SEL_EXECUTE_DATA = 6'b101000,
        SEL_EXECUTE_CTRL = 6'b101001,
        SEL_MEMST_DATA   = 6'b101010,
        SEL_MEMST_CTRL   = 6'b101011
    } debug_select_e;

    function automatic logic is_register_select(input logic [5:0] sel);
        return ~sel[5];
    endfunction

    function automatic logic [5:0] register_select(input logic [4:0] reg_num);
        return {1'b0, reg_num};
    endfunction

endpackage

// File: rtl/debug_ack_watchdog.sv
// Ack watchdog: counts cycles a frame sits unacknowledged and flags expiry for one cycle.
module debug_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);

    logic [NB_CNT-1:0] cnt_q;
    logic [NB_CNT-1:0] cnt_d;

    // Expiry lands in the TIMEOUT_CYCLES-th consecutive unacknowledged cycle.
    assign o_expired = i_run && !i_clear && (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + NB_CNT'(1);
        if (!i_run || i_clear || o_expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_readback_sequencer.sv
// Walks a debug source word by word and hands each word to the MicroBlaze, closing with an EOD frame.
// Optional ack watchdog enabled by defining DEBUG_SEQ_TIMEOUT_EN.
module debug_readback_sequencer
    import debug_pkg::*;
#(
    parameter int NB_FRAME       = 32,
    parameter int NB_SELECT      = 6,
    parameter int NB_WORD_CNT    = 5,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_request,
    input  logic [NB_SELECT-1:0]   i_select,
    input  logic [NB_WORD_CNT-1:0] i_word_count,
    output logic [NB_SELECT-1:0]   o_select,
    output logic                   o_rd_en,
    output logic [NB_WORD_CNT-1:0] o_word_idx,
    input  logic [NB_FRAME-1:0]    i_src_data,
    output logic [NB_FRAME-1:0]    o_frame,
    output logic                   o_frame_valid,
    input  logic                   i_frame_ack,
    output logic                   o_eod,
    output logic                   o_busy,
    output logic                   o_req_dropped,
    output logic                   o_timeout
);

    localparam int                    NB_LAT    = 3;
    localparam logic [NB_SELECT-1:0]  IDLE_SEL  = NB_SELECT'(IDLE_SELECT);
    localparam logic [NB_FRAME-1:0]   EOD_FRAME = NB_FRAME'(EOD_MARKER);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be within 1..4");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    seq_state_e             state_q, state_d;
    logic [NB_SELECT-1:0]   select_q, select_d;
    logic [NB_WORD_CNT-1:0] count_q, count_d;
    logic [NB_WORD_CNT-1:0] idx_q, idx_d;
    logic [NB_LAT-1:0]      lat_q, lat_d;
    logic [NB_FRAME-1:0]    frame_q, frame_d;
    logic                   rd_en_q, rd_en_d;
    logic                   valid_q, valid_d;
    logic                   eod_q, eod_d;
    logic                   busy_q, busy_d;
    logic                   dropped_q, dropped_d;
    logic                   timeout_q, timeout_d;

    logic lat_done;
    logic last_word;
    logic wd_expired;

    assign lat_done  = (lat_q == NB_LAT'(1));
    assign last_word = (idx_q == count_q - NB_WORD_CNT'(1));

`ifdef DEBUG_SEQ_TIMEOUT_EN
    debug_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ack_watchdog (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_run     (valid_q),
        .i_clear   (i_frame_ack),
        .o_expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            select_q  <= IDLE_SEL;
            count_q   <= '0;
            idx_q     <= '0;
            lat_q     <= '0;
            frame_q   <= '0;
            rd_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            eod_q     <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            frame_q   <= frame_d;
            rd_en_q   <= rd_en_d;
            valid_q   <= valid_d;
            eod_q     <= eod_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_request) begin
                    state_d = (i_word_count != '0) ? ST_ISSUE : ST_EOD;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lat_done) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_frame_ack) begin
                    state_d = last_word ? ST_EOD : ST_ISSUE;
                end else if (wd_expired) begin
                    state_d = ST_EOD;
                end
            end
            ST_EOD: begin
                if (i_frame_ack || wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        select_d  = select_q;
        count_d   = count_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        frame_d   = frame_q;
        dropped_d = i_request && busy_q;
        timeout_d = wd_expired;

        unique case (state_q)
            ST_IDLE: begin
                if (i_request) begin
                    select_d = i_select;
                    count_d  = i_word_count;
                    idx_d    = '0;
                end
            end
            ST_ISSUE: lat_d = NB_LAT'(READ_LATENCY);
            ST_WAIT: begin
                lat_d = lat_q - NB_LAT'(1);
                if (lat_done) begin
                    frame_d = i_src_data;
                end
            end
            ST_PRESENT: begin
                if (i_frame_ack && !last_word) begin
                    idx_d = idx_q + NB_WORD_CNT'(1);
                end
            end
            ST_EOD: begin
                if (state_d == ST_IDLE) begin
                    select_d = IDLE_SEL;
                end
            end
            default: ;
        endcase

        // A timed-out data frame is replaced by the marker on the way into EOD.
        if (state_d == ST_EOD) begin
            frame_d = EOD_FRAME;
        end

        rd_en_d = (state_d == ST_ISSUE);
        valid_d = (state_d == ST_PRESENT) || (state_d == ST_EOD);
        eod_d   = (state_d == ST_EOD);
        busy_d  = (state_d != ST_IDLE);
    end

    assign o_select      = select_q;
    assign o_rd_en       = rd_en_q;
    assign o_word_idx    = idx_q;
    assign o_frame       = frame_q;
    assign o_frame_valid = valid_q;
    assign o_eod         = eod_q;
    assign o_busy        = busy_q;
    assign o_req_dropped = dropped_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_debug_readback_sequencer.sv
// Scoreboard bench for debug_readback_sequencer: source model answers reads, monitor checks handshakes.
module tb_debug_readback_sequencer;
    import debug_pkg::*;

    localparam int NB_FRAME     = 32;
    localparam int NB_SELECT    = 6;
    localparam int NB_WORD_CNT  = 5;
    localparam int READ_LATENCY = 1;
`ifdef DEBUG_SEQ_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`else
    localparam int TIMEOUT_CYCLES = 1024;
`endif

    typedef struct packed {
        logic [NB_FRAME-1:0] frame;
        logic                eod;
    } frame_t;

    logic                   i_clock = 1'b0;
    logic                   i_reset = 1'b1;
    logic                   i_request = 1'b0;
    logic [NB_SELECT-1:0]   i_select = '0;
    logic [NB_WORD_CNT-1:0] i_word_count = '0;
    logic [NB_SELECT-1:0]   o_select;
    logic                   o_rd_en;
    logic [NB_WORD_CNT-1:0] o_word_idx;
    logic [NB_FRAME-1:0]    i_src_data = '0;
    logic [NB_FRAME-1:0]    o_frame;
    logic                   o_frame_valid;
    logic                   i_frame_ack = 1'b0;
    logic                   o_eod;
    logic                   o_busy;
    logic                   o_req_dropped;
    logic                   o_timeout;

    frame_t                 exp_frames[$];
    logic [NB_WORD_CNT-1:0] exp_idx[$];
    int                     n_compared   = 0;
    int                     n_mismatched = 0;
    int                     cycle        = 0;
    logic [15:0]            salt         = 16'h5A00;

    localparam logic [48:0] RESET_VECTOR = {6'h3F, 32'h0, 5'h0, 6'b000000};

    debug_readback_sequencer #(
        .NB_FRAME       (NB_FRAME),
        .NB_SELECT      (NB_SELECT),
        .NB_WORD_CNT    (NB_WORD_CNT),
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_request     (i_request),
        .i_select      (i_select),
        .i_word_count  (i_word_count),
        .o_select      (o_select),
        .o_rd_en       (o_rd_en),
        .o_word_idx    (o_word_idx),
        .i_src_data    (i_src_data),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_frame_ack   (i_frame_ack),
        .o_eod         (o_eod),
        .o_busy        (o_busy),
        .o_req_dropped (o_req_dropped),
        .o_timeout     (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) cycle <= cycle + 1;

    function automatic logic [NB_FRAME-1:0] src_word(input logic [NB_SELECT-1:0] sel,
                                                     input logic [NB_WORD_CNT-1:0] idx);
        return {salt, 2'b01, sel, 3'b000, idx};
    endfunction

    // Source model: answers one cycle after the read strobe, garbage otherwise.
    always @(posedge i_clock) begin
        if (o_rd_en) i_src_data <= src_word(o_select, o_word_idx);
        else         i_src_data <= {16'hBAD0, cycle[15:0]};
    end

    // Monitor: pops expectations on every read strobe and every accepted frame.
    always begin : monitor
        frame_t                 ef;
        logic [NB_WORD_CNT-1:0] ei;
        @(negedge i_clock);
        #1;
        if (!i_reset) begin
            if (o_rd_en) begin
                n_compared++;
                if (exp_idx.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL rd_en_unexpected: got idx=%0d, expected no read", o_word_idx);
                end else begin
                    ei = exp_idx.pop_front();
                    if (o_word_idx !== ei) begin
                        n_mismatched++;
                        $display("FAIL rd_idx: got %0d, expected %0d", o_word_idx, ei);
                    end
                end
            end
            if (o_frame_valid && i_frame_ack) begin
                n_compared++;
                if (exp_frames.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL frame_unexpected: got %h eod=%b, expected none", o_frame, o_eod);
                end else begin
                    ef = exp_frames.pop_front();
                    if ({o_frame, o_eod} !== ef) begin
                        n_mismatched++;
                        $display("FAIL frame: got %h eod=%b, expected %h eod=%b", o_frame, o_eod, ef.frame, ef.eod);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish, expected finish before limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge i_clock);
    endtask

    task automatic push_strip(input logic [NB_SELECT-1:0] sel, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_idx.push_back(NB_WORD_CNT'(i));
            exp_frames.push_back({src_word(sel, NB_WORD_CNT'(i)), 1'b0});
        end
        exp_frames.push_back({EOD_MARKER, 1'b1});
    endtask

    task automatic request(input logic [NB_SELECT-1:0] sel, input int cnt);
        i_request    = 1'b1;
        i_select     = sel;
        i_word_count = NB_WORD_CNT'(cnt);
        tick();
        i_request    = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_frame_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [48:0] got;
        i_reset = 1'b1;
        repeat (3) tick();
        got = {o_select, o_frame, o_word_idx, o_rd_en, o_frame_valid, o_eod, o_busy, o_req_dropped, o_timeout};
        n_compared++;
        if (got !== RESET_VECTOR) begin
            n_mismatched++;
            $display("FAIL reset_values: got %h, expected %h", got, RESET_VECTOR);
        end
        i_reset = 1'b0;
        tick();
        got = {o_select, o_frame, o_word_idx, o_rd_en, o_frame_valid, o_eod, o_busy, o_req_dropped, o_timeout};
        n_compared++;
        if (got !== RESET_VECTOR) begin
            n_mismatched++;
            $display("FAIL idle_after_reset: got %h, expected %h", got, RESET_VECTOR);
        end
    endtask

    task automatic test_basic_strip();
        int rd_at[$];
        int first_valid = -1;
        int eod_at      = -1;
        int done_at     = -1;
        logic [NB_FRAME-1:0] eod_frame = '0;
        salt        = 16'h1234;
        i_frame_ack = 1'b1;
        push_strip(SEL_FETCH_DATA, 3);
        request(SEL_FETCH_DATA, 3);
        for (int k = 1; k <= 60; k++) begin
            if (o_rd_en) rd_at.push_back(k);
            if (o_frame_valid && first_valid < 0) first_valid = k;
            if (o_eod && eod_at < 0) begin
                eod_at    = k;
                eod_frame = o_frame;
            end
            if (!o_busy) begin
                done_at = k;
                break;
            end
            tick();
        end
        i_frame_ack = 1'b0;
        n_compared++;
        if (first_valid != READ_LATENCY + 2) begin
            n_mismatched++;
            $display("FAIL first_valid_latency: got %0d, expected %0d", first_valid, READ_LATENCY + 2);
        end
        n_compared++;
        if (rd_at.size() != 3 || rd_at[0] != 1 || rd_at[1] != 4 || rd_at[2] != 7) begin
            n_mismatched++;
            $display("FAIL rd_en_cycles: got %p, expected '{1, 4, 7}", rd_at);
        end
        n_compared++;
        if (eod_at != 10 || eod_frame !== EOD_MARKER) begin
            n_mismatched++;
            $display("FAIL eod_frame: got cycle %0d frame %h, expected cycle 10 frame %h", eod_at, eod_frame, EOD_MARKER);
        end
        n_compared++;
        if (done_at != 11 || o_select !== IDLE_SELECT) begin
            n_mismatched++;
            $display("FAIL strip_end: got cycle %0d select %b, expected cycle 11 select %b", done_at, o_select, IDLE_SELECT);
        end
    endtask

    task automatic test_zero_count();
        int rd_seen = 0;
        salt        = 16'h0F0F;
        i_frame_ack = 1'b0;
        push_strip(SEL_PC, 0);
        request(SEL_PC, 0);
        n_compared++;
        if ({o_frame_valid, o_eod, o_busy, o_frame} !== {3'b111, EOD_MARKER}) begin
            n_mismatched++;
            $display("FAIL zero_count_eod: got valid=%b eod=%b busy=%b frame=%h, expected 1 1 1 %h", o_frame_valid, o_eod, o_busy, o_frame, EOD_MARKER);
        end
        for (int i = 0; i < 3; i++) begin
            if (o_rd_en) rd_seen++;
            tick();
        end
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        n_compared++;
        if (rd_seen != 0 || o_rd_en !== 1'b0) begin
            n_mismatched++;
            $display("FAIL zero_count_rd_en: got %0d strobes, expected 0", rd_seen);
        end
        n_compared++;
        if ({o_busy, o_frame_valid, o_select} !== {2'b00, IDLE_SELECT}) begin
            n_mismatched++;
            $display("FAIL zero_count_end: got busy=%b valid=%b select=%b, expected 0 0 %b", o_busy, o_frame_valid, o_select, IDLE_SELECT);
        end
    endtask

    task automatic test_ack_withheld();
        bit ok;
        int bad = 0;
        logic [NB_FRAME-1:0] held;
        salt        = 16'hC0DE;
        i_frame_ack = 1'b0;
        push_strip(SEL_EXECUTE_DATA, 2);
        request(SEL_EXECUTE_DATA, 2);
        wait_valid(20, ok);
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        wait_valid(20, ok);
        n_compared++;
        if (!ok || o_word_idx !== 5'd1) begin
            n_mismatched++;
            $display("FAIL withheld_reach_word1: got valid=%b idx=%0d, expected 1 1", ok, o_word_idx);
        end
        held = o_frame;
        for (int i = 0; i < 10; i++) begin
            if (o_frame_valid !== 1'b1 || o_frame !== held || o_rd_en !== 1'b0 || o_timeout !== 1'b0) bad++;
            tick();
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("FAIL withheld_hold: got %0d unstable cycles, expected 0", bad);
        end
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        wait_valid(20, ok);
        n_compared++;
        if (!ok || o_eod !== 1'b1) begin
            n_mismatched++;
            $display("FAIL withheld_eod: got valid=%b eod=%b, expected 1 1", ok, o_eod);
        end
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
    endtask

    task automatic test_request_drop();
        bit ok;
        salt        = 16'h7E57;
        i_frame_ack = 1'b0;
        push_strip(SEL_MEMST_CTRL, 2);
        request(SEL_MEMST_CTRL, 2);
        wait_valid(20, ok);
        request(6'b000101, 7);
        n_compared++;
        if (o_req_dropped !== 1'b1 || o_select !== SEL_MEMST_CTRL) begin
            n_mismatched++;
            $display("FAIL drop_in_present: got dropped=%b select=%b, expected 1 %b", o_req_dropped, o_select, SEL_MEMST_CTRL);
        end
        tick();
        n_compared++;
        if (o_req_dropped !== 1'b0) begin
            n_mismatched++;
            $display("FAIL drop_pulse_width: got %b, expected 0", o_req_dropped);
        end
        i_frame_ack = 1'b1;
        for (int i = 0; i < 40 && !o_eod; i++) tick();
        request(SEL_PC, 4);
        n_compared++;
        if ({o_req_dropped, o_busy, o_select} !== {2'b10, IDLE_SELECT}) begin
            n_mismatched++;
            $display("FAIL drop_on_eod_ack: got dropped=%b busy=%b select=%b, expected 1 0 %b", o_req_dropped, o_busy, o_select, IDLE_SELECT);
        end
        tick();
        i_frame_ack = 1'b0;
        n_compared++;
        if ({o_busy, o_rd_en, o_frame_valid} !== 3'b000) begin
            n_mismatched++;
            $display("FAIL drop_not_latched: got busy=%b rd_en=%b valid=%b, expected 0 0 0", o_busy, o_rd_en, o_frame_valid);
        end
    endtask

    task automatic test_reset_mid_strip();
        logic [48:0] got;
        int activity = 0;
        salt        = 16'hFACE;
        i_frame_ack = 1'b0;
        push_strip(SEL_DECODE_CTRL, 3);
        request(SEL_DECODE_CTRL, 3);
        tick();
        i_reset = 1'b1;
        tick();
        got = {o_select, o_frame, o_word_idx, o_rd_en, o_frame_valid, o_eod, o_busy, o_req_dropped, o_timeout};
        n_compared++;
        if (got !== RESET_VECTOR) begin
            n_mismatched++;
            $display("FAIL reset_mid_strip: got %h, expected %h", got, RESET_VECTOR);
        end
        i_reset = 1'b0;
        exp_idx.delete();
        exp_frames.delete();
        i_frame_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (o_frame_valid || o_eod || o_busy || o_rd_en) activity++;
            tick();
        end
        i_frame_ack = 1'b0;
        n_compared++;
        if (activity != 0) begin
            n_mismatched++;
            $display("FAIL reset_no_eod: got %0d active cycles, expected 0", activity);
        end
    endtask

`ifdef DEBUG_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int to_at[$];
        int idle_at = -1;
        logic [NB_FRAME-1:0] first_to_frame = '0;
        logic                first_to_eod   = 1'b0;
        salt        = 16'hD06E;
        i_frame_ack = 1'b0;
        exp_idx.push_back('0);
        request(SEL_DECODE_DATA, 1);
        for (int k = 1; k <= 60; k++) begin
            if (o_timeout) begin
                if (to_at.size() == 0) begin
                    first_to_frame = o_frame;
                    first_to_eod   = o_eod && o_frame_valid;
                end
                to_at.push_back(k);
            end
            if (!o_busy && idle_at < 0) idle_at = k;
            tick();
        end
        n_compared++;
        if (to_at.size() != 2 || to_at[0] != 19 || to_at[1] != 35) begin
            n_mismatched++;
            $display("FAIL timeout_pulses: got %p, expected '{19, 35}", to_at);
        end
        n_compared++;
        if (first_to_frame !== EOD_MARKER || first_to_eod !== 1'b1) begin
            n_mismatched++;
            $display("FAIL timeout_eod_frame: got %h eod=%b, expected %h eod=1", first_to_frame, first_to_eod, EOD_MARKER);
        end
        n_compared++;
        if (idle_at != 35) begin
            n_mismatched++;
            $display("FAIL timeout_idle: got cycle %0d, expected 35", idle_at);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_strip();
        test_zero_count();
        test_ack_withheld();
        test_request_drop();
        test_reset_mid_strip();
`ifdef DEBUG_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) tick();
        n_compared++;
        if (exp_frames.size() != 0 || exp_idx.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_drain: got %0d frames %0d reads left, expected 0 0", exp_frames.size(), exp_idx.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
